// File: rtl/rr_resource_scheduler_if.sv
// Request/release/grant bundle between requesting pipeline stages and the scheduler.
// The requester side uses the master modport; the scheduler uses the slave modport.
interface rr_resource_scheduler_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  modport master (
    output req, done,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/rr_resource_scheduler.sv
// N-way round-robin scheduler for one shared resource: one grant is held until release, then priority rotates.
// Optional forced release after MAX_HOLD cycles is enabled with the ARB_TIMEOUT_EN macro.
module rr_resource_scheduler #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  rr_resource_scheduler_if.slave sched
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_resource_scheduler: unsupported N/MAX_HOLD");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          release_w;
  logic          forced_w;
  logic [IW-1:0] rot_ptr;
  logic [IW-1:0] search_ptr;
  logic [N-1:0]  elig;
  logic          found;
  logic [IW-1:0] winner;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;

  // Forced release fires on the MAX_HOLD-th granted cycle, only if no natural release happens then.
  assign forced_w = (state_q == S_GRANT) && ((hold_q + HW'(1)) == HW'(MAX_HOLD)) &&
                    !sched.done[gid_q] && sched.req[gid_q];

  always_comb begin
    hold_d = '0;
    if (state_q == S_GRANT && !release_w) hold_d = hold_q + HW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`else
  assign forced_w = 1'b0;
`endif

  assign release_w = (state_q == S_GRANT) &&
                     (sched.done[gid_q] || !sched.req[gid_q] || forced_w);
  assign rot_ptr   = (gid_q == IW'(N - 1)) ? '0 : gid_q + IW'(1);

  // On release, arbitrate from the rotated pointer with the releasing index masked out.
  always_comb begin
    search_ptr = ptr_q;
    elig       = sched.req;
    if (release_w) begin
      search_ptr   = rot_ptr;
      elig[gid_q]  = 1'b0;
    end
  end

  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(search_ptr) + i) % N;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d         = S_GRANT;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          gid_d           = winner;
        end
      end
      S_GRANT: begin
        if (release_w) begin
          ptr_d = rot_ptr;
          if (found) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            gid_d           = winner;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sched.grant    = grant_q;
  assign sched.grant_id = gid_q;
  assign sched.busy     = |grant_q;
  assign sched.timeout  = forced_w;
endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Directed bench for rr_resource_scheduler (N=4, MAX_HOLD=8); expected values are hand-computed.
// Timeout expectations follow the ARB_TIMEOUT_EN macro.
module tb_rr_resource_scheduler;
  logic clk = 1'b0;
  logic reset_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rr_resource_scheduler_if #(.N(4)) sif ();

  rr_resource_scheduler #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sched   (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] id, input logic b);
    chk({tag, ".grant"}, 32'(sif.grant), 32'(g));
    chk({tag, ".id"},    32'(sif.grant_id), 32'(id));
    chk({tag, ".busy"},  32'(sif.busy), 32'(b));
  endtask

  initial begin
    reset_n  = 1'b0;
    sif.req  = '0;
    sif.done = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_grant("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.timeout", 32'(sif.timeout), 32'd0);
    reset_n = 1'b1;

    // All requesting, done pulsed on the granted index each cycle: 0,1,2,3,0,1,2,3 back-to-back
    sif.req = 4'b1111;
    step();
    chk_grant("rr0", 4'b0001, 2'd0, 1'b1);
    for (int k = 1; k < 8; k++) begin
      sif.done = 4'(1 << ((k - 1) % 4));
      step();
      chk_grant($sformatf("rr%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1);
    end
    sif.done = 4'b1000;
    sif.req  = 4'b0000;
    step();
    chk_grant("rr_end", 4'b0000, 2'd3, 1'b0);
    sif.done = '0;

    // Pointer wraps to 0; 0 not requesting so 1 wins, then 3
    sif.req = 4'b1010;
    step();
    chk_grant("wrap1", 4'b0010, 2'd1, 1'b1);
    sif.done = 4'b0010;
    step();
    chk_grant("wrap3", 4'b1000, 2'd3, 1'b1);
    sif.done = 4'b1000;
    sif.req  = 4'b0000;
    step();
    chk_grant("wrap_idle", 4'b0000, 2'd3, 1'b0);
    sif.done = '0;

    // Single request, release by done
    sif.req = 4'b0100;
    step();
    chk_grant("single", 4'b0100, 2'd2, 1'b1);
    sif.done = 4'b0100;
    sif.req  = 4'b0000;
    step();
    chk_grant("single_rel", 4'b0000, 2'd2, 1'b0);
    sif.done = '0;

    // done on non-granted indices ignored; req drop aborts
    sif.req = 4'b0010;
    step();
    chk_grant("hold1", 4'b0010, 2'd1, 1'b1);
    sif.done = 4'b0101;
    step();
    chk_grant("ign_done", 4'b0010, 2'd1, 1'b1);
    sif.done = '0;
    step();
    chk_grant("still1", 4'b0010, 2'd1, 1'b1);
    sif.req = 4'b0000;
    step();
    chk_grant("abort", 4'b0000, 2'd1, 1'b0);

    // Releasing index masked for one cycle, then re-requests (ptr=2 -> 1 still wins alone)
    sif.req = 4'b0010;
    step();
    chk_grant("mask_g", 4'b0010, 2'd1, 1'b1);
    sif.done = 4'b0010;
    step();
    chk_grant("mask_bubble", 4'b0000, 2'd1, 1'b0);
    sif.done = '0;
    step();
    chk_grant("mask_regrant", 4'b0010, 2'd1, 1'b1);

    // New request arriving with done is eligible in the same arbitration
    sif.req  = 4'b0011;
    sif.done = 4'b0010;
    step();
    chk_grant("same_cycle", 4'b0001, 2'd0, 1'b1);
    sif.done = 4'b0001;
    sif.req  = 4'b0000;
    step();
    chk_grant("same_idle", 4'b0000, 2'd0, 1'b0);
    sif.done = '0;

    // Hold without done (ptr=1, so search 1,2,3,0 -> 1 wins first here)
    sif.req = 4'b0011;
    step();
    chk_grant("to_start", 4'b0010, 2'd1, 1'b1);
    for (int c = 2; c <= 7; c++) begin
      step();
      chk($sformatf("to_hold%0d.id", c), 32'(sif.grant_id), 32'd1);
      chk($sformatf("to_hold%0d.to", c), 32'(sif.timeout), 32'd0);
    end
    step();
    chk("to_cyc8.id", 32'(sif.grant_id), 32'd1);
`ifdef ARB_TIMEOUT_EN
    chk("to_cyc8.to", 32'(sif.timeout), 32'd1);
    step();
    chk_grant("to_next", 4'b0001, 2'd0, 1'b1);
    chk("to_next.to", 32'(sif.timeout), 32'd0);
`else
    chk("to_cyc8.to", 32'(sif.timeout), 32'd0);
    repeat (4) step();
    chk_grant("no_to", 4'b0010, 2'd1, 1'b1);
    chk("no_to.to", 32'(sif.timeout), 32'd0);
`endif
    sif.req = 4'b0000;
    step();
    chk("to_idle.busy", 32'(sif.busy), 32'd0);

    // Asynchronous reset mid-grant clears outputs before the next edge
    sif.req = 4'b0100;
    step();
    chk_grant("pre_rst", 4'b0100, 2'd2, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_grant("async_rst", 4'b0000, 2'd0, 1'b0);
    sif.req = 4'b0001;
    step();
    reset_n = 1'b1;
    step();
    chk_grant("post_rst", 4'b0001, 2'd0, 1'b1);
    sif.done = 4'b0001;
    sif.req  = 4'b0000;
    step();
    chk_grant("post_rst_idle", 4'b0000, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
